// File: rtl/mvm_job_arbiter_pkg.sv
// Shared types and sizing for the MVM job arbiter: FSM encoding, default engine geometry
// and the saturating counter helper used by the optional performance counters.
package mvm_arb_pkg;

    localparam int DEF_N_ROWS   = 8;
    localparam int DEF_N_COLS   = 8;
    localparam int W_WORDS      = DEF_N_ROWS * DEF_N_COLS;
    localparam int JOB_WORDS_NM = W_WORDS + DEF_N_COLS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DRAIN   = 2'd2
    } arb_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/mvm_job_arbiter_if.sv
// Stream bundle between the two requesters, the arbiter and the shared engine.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mvm_job_arbiter_if #(
    parameter int WIDTH     = 14,
    parameter int OUT_WIDTH = 28
);
    logic                 req0_valid, req0_ready, req0_new_matrix;
    logic [WIDTH-1:0]     req0_data;
    logic                 req1_valid, req1_ready, req1_new_matrix;
    logic [WIDTH-1:0]     req1_data;
    logic                 eng_input_valid, eng_input_ready, eng_new_matrix;
    logic [WIDTH-1:0]     eng_input_data;
    logic                 eng_output_valid, eng_output_ready;
    logic [OUT_WIDTH-1:0] eng_output_data;
    logic                 rsp0_valid, rsp0_ready;
    logic [OUT_WIDTH-1:0] rsp0_data;
    logic                 rsp1_valid, rsp1_ready;
    logic [OUT_WIDTH-1:0] rsp1_data;

    modport slave (
        input  req0_valid, req0_data, req0_new_matrix, output req0_ready,
        input  req1_valid, req1_data, req1_new_matrix, output req1_ready,
        output eng_input_valid, eng_input_data, eng_new_matrix, input eng_input_ready,
        input  eng_output_valid, eng_output_data, output eng_output_ready,
        output rsp0_valid, rsp0_data, input rsp0_ready,
        output rsp1_valid, rsp1_data, input rsp1_ready
    );

    modport master (
        output req0_valid, req0_data, req0_new_matrix, input req0_ready,
        output req1_valid, req1_data, req1_new_matrix, input req1_ready,
        input  eng_input_valid, eng_input_data, eng_new_matrix, output eng_input_ready,
        output eng_output_valid, eng_output_data, input eng_output_ready,
        input  rsp0_valid, rsp0_data, output rsp0_ready,
        input  rsp1_valid, rsp1_data, output rsp1_ready
    );

endinterface

// File: rtl/mvm_job_arbiter_rr_pick2.sv
// Two-way round-robin picker: the prio requester wins when valid, otherwise the other one.
module rr_pick2 (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic       winner_o,
    output logic       any_o
);

    // winner selection favouring prio_i
    always_comb begin
        any_o = |valid_i;
        if (valid_i[prio_i]) begin
            winner_o = prio_i;
        end else begin
            winner_o = ~prio_i;
        end
    end

endmodule

// File: rtl/mvm_job_arbiter.sv
// Job-granular round-robin arbiter sharing one matrix-vector engine between two streams.
// Optional perf counters (jobs0_cnt, jobs1_cnt, stall_cnt) are built when MVM_ARB_PERF_EN is defined.
module mvm_job_arbiter
    import mvm_arb_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int OUT_WIDTH = 28,
    parameter int N_ROWS    = DEF_N_ROWS,
    parameter int N_COLS    = DEF_N_COLS
) (
    input  logic              clk,
    input  logic              reset,
    mvm_job_arbiter_if.slave  arb_if,
    output logic              grant_id,
    output logic              busy,
    output logic              err_stale_w
`ifdef MVM_ARB_PERF_EN
    ,
    output logic [31:0]       jobs0_cnt,
    output logic [31:0]       jobs1_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int RES_W = $clog2(N_ROWS) + 1;

    arb_state_t       state_q, state_d;
    logic             prio_q, prio_d;
    logic             grant_q, grant_d;
    logic             first_nm_q, first_nm_d;
    logic             first_word_q, first_word_d;
    logic [6:0]       word_cnt_q, word_cnt_d;
    logic [RES_W-1:0] res_cnt_q, res_cnt_d;
    logic             w_owner_q, w_owner_d;
    logic             w_owner_valid_q, w_owner_valid_d;
    logic             err_q, err_d;

    logic             winner_s, any_s, pick_nm_s;
    logic             g_valid_s, g_rsp_ready_s;
    logic [WIDTH-1:0] g_data_s;

    rr_pick2 u_pick (
        .valid_i  ({arb_if.req1_valid, arb_if.req0_valid}),
        .prio_i   (prio_q),
        .winner_o (winner_s),
        .any_o    (any_s)
    );

    // next-state logic and the per-state stream routing
    always_comb begin
        state_d         = state_q;
        prio_d          = prio_q;
        grant_d         = grant_q;
        first_nm_d      = first_nm_q;
        first_word_d    = first_word_q;
        word_cnt_d      = word_cnt_q;
        res_cnt_d       = res_cnt_q;
        w_owner_d       = w_owner_q;
        w_owner_valid_d = w_owner_valid_q;
        err_d           = 1'b0;

        arb_if.req0_ready       = 1'b0;
        arb_if.req1_ready       = 1'b0;
        arb_if.eng_input_valid  = 1'b0;
        arb_if.eng_input_data   = {WIDTH{1'b0}};
        arb_if.eng_new_matrix   = 1'b0;
        arb_if.eng_output_ready = 1'b0;
        arb_if.rsp0_valid       = 1'b0;
        arb_if.rsp1_valid       = 1'b0;
        arb_if.rsp0_data        = {OUT_WIDTH{1'b0}};
        arb_if.rsp1_data        = {OUT_WIDTH{1'b0}};

        g_valid_s     = grant_q ? arb_if.req1_valid : arb_if.req0_valid;
        g_data_s      = grant_q ? arb_if.req1_data  : arb_if.req0_data;
        g_rsp_ready_s = grant_q ? arb_if.rsp1_ready : arb_if.rsp0_ready;
        pick_nm_s     = winner_s ? arb_if.req1_new_matrix : arb_if.req0_new_matrix;

        case (state_q)
            IDLE: begin
                if (any_s) begin
                    grant_d      = winner_s;
                    first_nm_d   = pick_nm_s;
                    first_word_d = 1'b1;
                    word_cnt_d   = pick_nm_s ? 7'(N_ROWS * N_COLS + N_COLS) : 7'(N_COLS);
                    // x-only job computes against whatever W the engine holds; flag a mismatch
                    err_d        = ~pick_nm_s & (~w_owner_valid_q | (w_owner_q != winner_s));
                    state_d      = FORWARD;
                end else begin
                    state_d = IDLE;
                end
            end
            FORWARD: begin
                arb_if.eng_input_valid = g_valid_s;
                arb_if.eng_input_data  = g_data_s;
                arb_if.eng_new_matrix  = first_nm_q & first_word_q;
                if (grant_q) begin
                    arb_if.req1_ready = arb_if.eng_input_ready;
                end else begin
                    arb_if.req0_ready = arb_if.eng_input_ready;
                end
                if (g_valid_s && arb_if.eng_input_ready) begin
                    first_word_d = 1'b0;
                    word_cnt_d   = word_cnt_q - 7'd1;
                    if (word_cnt_q == 7'd1) begin
                        state_d   = DRAIN;
                        res_cnt_d = RES_W'(N_ROWS);
                        if (first_nm_q) begin
                            w_owner_d       = grant_q;
                            w_owner_valid_d = 1'b1;
                        end else begin
                            w_owner_d       = w_owner_q;
                        end
                    end else begin
                        state_d = FORWARD;
                    end
                end else begin
                    state_d = FORWARD;
                end
            end
            DRAIN: begin
                arb_if.eng_output_ready = g_rsp_ready_s;
                if (grant_q) begin
                    arb_if.rsp1_valid = arb_if.eng_output_valid;
                    arb_if.rsp1_data  = arb_if.eng_output_data;
                end else begin
                    arb_if.rsp0_valid = arb_if.eng_output_valid;
                    arb_if.rsp0_data  = arb_if.eng_output_data;
                end
                if (arb_if.eng_output_valid && g_rsp_ready_s) begin
                    res_cnt_d = res_cnt_q - RES_W'(1);
                    if (res_cnt_q == RES_W'(1)) begin
                        state_d = IDLE;
                        prio_d  = ~grant_q;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            prio_q          <= 1'b0;
            grant_q         <= 1'b0;
            first_nm_q      <= 1'b0;
            first_word_q    <= 1'b0;
            word_cnt_q      <= 7'd0;
            res_cnt_q       <= {RES_W{1'b0}};
            w_owner_q       <= 1'b0;
            w_owner_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            prio_q          <= prio_d;
            grant_q         <= grant_d;
            first_nm_q      <= first_nm_d;
            first_word_q    <= first_word_d;
            word_cnt_q      <= word_cnt_d;
            res_cnt_q       <= res_cnt_d;
            w_owner_q       <= w_owner_d;
            w_owner_valid_q <= w_owner_valid_d;
            err_q           <= err_d;
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign err_stale_w = err_q;

`ifdef MVM_ARB_PERF_EN
    logic        job_done_s, stall_s;
    logic [31:0] jobs0_q, jobs1_q, stall_q;

    assign job_done_s = (state_q == DRAIN) && arb_if.eng_output_valid && g_rsp_ready_s
                        && (res_cnt_q == RES_W'(1));
    assign stall_s    = (state_q == DRAIN) && arb_if.eng_output_valid && !g_rsp_ready_s;

    // saturating job and back-pressure counters
    always_ff @(posedge clk) begin
        if (reset) begin
            jobs0_q <= 32'd0;
            jobs1_q <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            jobs0_q <= (job_done_s && !grant_q) ? sat_inc32(jobs0_q) : jobs0_q;
            jobs1_q <= (job_done_s &&  grant_q) ? sat_inc32(jobs1_q) : jobs1_q;
            stall_q <= stall_s ? sat_inc32(stall_q) : stall_q;
        end
    end

    assign jobs0_cnt = jobs0_q;
    assign jobs1_cnt = jobs1_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mvm_job_arbiter.sv
// Directed bench for mvm_job_arbiter with queue-driven requesters, result sinks and a
// behavioural 8x8 engine model; expected results are hand-computed from the chosen W and x.
`timescale 1ns/1ps
module tb_mvm_job_arbiter;

    localparam int WIDTH     = 14;
    localparam int OUT_WIDTH = 28;

    logic clk;
    logic reset;
    logic grant_id, busy, err_stale_w;
`ifdef MVM_ARB_PERF_EN
    logic [31:0] jobs0_cnt, jobs1_cnt, stall_cnt;
`endif

    mvm_job_arbiter_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    mvm_job_arbiter #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .N_ROWS(8), .N_COLS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .arb_if      (bus),
        .grant_id    (grant_id),
        .busy        (busy),
`ifdef MVM_ARB_PERF_EN
        .jobs0_cnt   (jobs0_cnt),
        .jobs1_cnt   (jobs1_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .err_stale_w (err_stale_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] q0[$];
    logic [WIDTH:0] q1[$];
    int rx0[$];
    int rx1[$];
    int grants[$];
    int sent0 = 0, sent1 = 0;
    int stall_at0 = -1, stall_left0 = 0;
    int eng_words = 0, nm_first = 0, nm_late = 0;
    int err_cnt = 0, err_grant = 0;

    // requester 0 source: one word per accepted transfer, optional mid-job valid gap
    initial begin
        bit fire;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_new_matrix = 1'b0;
        forever begin
            @(negedge clk); fire = bus.req0_valid && bus.req0_ready;
            @(posedge clk); #1;
            if (fire) begin q0.delete(0); sent0++; end
            if (q0.size() > 0 && sent0 == stall_at0 && stall_left0 > 0) begin
                stall_left0--; bus.req0_valid = 1'b0;
            end else if (q0.size() > 0) begin
                bus.req0_valid = 1'b1; bus.req0_new_matrix = q0[0][WIDTH]; bus.req0_data = q0[0][WIDTH-1:0];
            end else begin
                bus.req0_valid = 1'b0;
            end
        end
    end

    // requester 1 source
    initial begin
        bit fire;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_new_matrix = 1'b0;
        forever begin
            @(negedge clk); fire = bus.req1_valid && bus.req1_ready;
            @(posedge clk); #1;
            if (fire) begin q1.delete(0); sent1++; end
            if (q1.size() > 0) begin
                bus.req1_valid = 1'b1; bus.req1_new_matrix = q1[0][WIDTH]; bus.req1_data = q1[0][WIDTH-1:0];
            end else begin
                bus.req1_valid = 1'b0;
            end
        end
    end

    // result sinks and grant/error monitors
    initial begin
        bit bprev;
        bprev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rsp0_valid && bus.rsp0_ready) rx0.push_back(int'(bus.rsp0_data));
            if (bus.rsp1_valid && bus.rsp1_ready) rx1.push_back(int'(bus.rsp1_data));
            if (err_stale_w) begin err_cnt++; err_grant = int'(grant_id); end
            if (busy && !bprev) grants.push_back(int'(grant_id));
            bprev = busy;
        end
    end

    // behavioural engine: 72 words (W then x) or 8 words (x), then 8 results y = W*x
    initial begin
        int ew[64]; int ex[8]; int eres[8];
        int eidx, eexp, eridx;
        bit eout, in_fire, out_fire, nm;
        int d;
        eidx = 0; eexp = 8; eridx = 0; eout = 1'b0;
        foreach (ew[i]) ew[i] = 0;
        bus.eng_input_ready = 1'b0; bus.eng_output_valid = 1'b0; bus.eng_output_data = '0;
        forever begin
            @(negedge clk);
            in_fire  = bus.eng_input_valid && bus.eng_input_ready;
            out_fire = bus.eng_output_valid && bus.eng_output_ready;
            nm = bus.eng_new_matrix; d = int'(bus.eng_input_data);
            @(posedge clk); #1;
            if (reset) begin
                eidx = 0; eridx = 0; eout = 1'b0;
            end else begin
                if (in_fire) begin
                    eng_words++;
                    if (eidx == 0) eexp = nm ? 72 : 8;
                    if (nm) begin if (eidx == 0) nm_first++; else nm_late++; end
                    if (eexp == 72 && eidx < 64) ew[eidx] = d; else ex[eidx - (eexp - 8)] = d;
                    eidx++;
                    if (eidx == eexp) begin
                        for (int r = 0; r < 8; r++) begin
                            eres[r] = 0;
                            for (int c = 0; c < 8; c++) eres[r] += ew[r*8+c] * ex[c];
                        end
                        eout = 1'b1; eridx = 0; eidx = 0;
                    end
                end
                if (out_fire) begin eridx++; if (eridx == 8) eout = 1'b0; end
            end
            bus.eng_input_ready  = !eout;
            bus.eng_output_valid = eout;
            bus.eng_output_data  = eout ? OUT_WIDTH'(eres[eridx]) : '0;
        end
    end

    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rx0.delete(); rx1.delete(); grants.delete();
        eng_words = 0; nm_first = 0; nm_late = 0; err_cnt = 0; sent0 = 0; sent1 = 0;
    endtask

    // nm jobs: 64 words of diag*I then x, new_matrix set on every word (only the first counts);
    // x-only jobs: new_matrix clear on word 0 and set on later words, which must be ignored
    task automatic push_job(input int r, input bit nm, input int diag, input int xbase, input int xstep);
        logic [WIDTH:0] w;
        if (nm) begin
            for (int i = 0; i < 64; i++) begin
                w = {1'b1, WIDTH'(((i / 8) == (i % 8)) ? diag : 0)};
                if (r == 0) q0.push_back(w); else q1.push_back(w);
            end
        end
        for (int i = 0; i < 8; i++) begin
            w = {(nm || i != 0), WIDTH'(xbase + xstep * i)};
            if (r == 0) q0.push_back(w); else q1.push_back(w);
        end
    endtask

    task automatic check_rx(input string tag, input int r, input int n, input int base, input int step);
        check({tag, "_count"}, (r == 0) ? rx0.size() : rx1.size(), n);
        for (int i = 0; i < n && i < ((r == 0) ? rx0.size() : rx1.size()); i++)
            check(tag, (r == 0) ? rx0[i] : rx1[i], base + step * i);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (busy || q0.size() > 0 || q1.size() > 0); i++) tick();
        check("wait_idle_timeout", int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_grant", int'(grant_id), 0);
        check("rst_err", int'(err_stale_w), 0);
        check("rst_req_ready", int'({bus.req0_ready, bus.req1_ready}), 0);
        check("rst_eng_valid_ready", int'({bus.eng_input_valid, bus.eng_output_ready, bus.eng_new_matrix}), 0);
        check("rst_rsp_valid", int'({bus.rsp0_valid, bus.rsp1_valid}), 0);

        // req0 loads W = I, x = 1..8
        clear_logs();
        push_job(0, 1'b1, 1, 1, 1);
        wait_idle();
        check_rx("t1_rsp0", 0, 8, 1, 1);
        check("t1_rsp1_none", rx1.size(), 0);
        check("t1_eng_words", eng_words, 72);
        check("t1_nm_first", nm_first, 1);
        check("t1_nm_late", nm_late, 0);
        check("t1_err", err_cnt, 0);

        // req1 x-only against W owned by req0: stale pulse, results x itself
        clear_logs();
        push_job(1, 1'b0, 0, 11, 1);
        wait_idle();
        check_rx("t1b_rsp1", 1, 8, 11, 1);
        check("t1b_err", err_cnt, 1);
        check("t1b_err_grant", err_grant, 1);

        // both valid in IDLE with prio back at 0
        clear_logs();
        push_job(0, 1'b0, 0, 21, 1);
        push_job(1, 1'b0, 0, 31, 1);
        wait_idle();
        check("t2_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            check("t2_first", grants[0], 0);
            check("t2_second", grants[1], 1);
        end
        check_rx("t2_rsp0", 0, 8, 21, 1);
        check_rx("t2_rsp1", 1, 8, 31, 1);
        check("t2_err", err_cnt, 1);
        check("t2_err_grant", err_grant, 1);
        check("t2_nm_late", nm_late, 0);

        // req1 loads W = 2I with x = 3, then x-only x = 5
        clear_logs();
        push_job(1, 1'b1, 2, 3, 0);
        push_job(1, 1'b0, 0, 5, 0);
        wait_idle();
        check("t3_count", rx1.size(), 16);
        for (int i = 0; i < rx1.size(); i++) check("t3_rsp1", rx1[i], (i < 8) ? 6 : 10);
        check("t3_err", err_cnt, 0);
        check("t3_rsp0_none", rx0.size(), 0);

        // rsp0 back-pressure mid-drain (W = 2I owned by req1)
        clear_logs();
        push_job(0, 1'b0, 0, 41, 1);
        for (int i = 0; i < 500 && rx0.size() < 3; i++) tick();
        bus.rsp0_ready = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            check("t4_eng_out_ready", int'(bus.eng_output_ready), 0);
            check("t4_rsp0_valid", int'(bus.rsp0_valid), 1);
            tick();
        end
        check("t4_held_count", rx0.size(), 3);
        bus.rsp0_ready = 1'b1;
        wait_idle();
        check_rx("t4_rsp0", 0, 8, 82, 2);
        check("t4_err", err_cnt, 1);
        check("t4_err_grant", err_grant, 0);

        // req0 gap of 5 cycles after word 40 while req1 waits
        clear_logs();
        stall_at0 = 40; stall_left0 = 5;
        push_job(0, 1'b1, 1, 1, 1);
        for (int i = 0; i < 100 && !(busy && grant_id == 1'b0); i++) tick();
        push_job(1, 1'b0, 0, 51, 1);
        for (int i = 0; i < 200 && sent0 < 40; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_req0_valid", int'(bus.req0_valid), 0);
            check("t5_req1_ready", int'(bus.req1_ready), 0);
            check("t5_req1_valid", int'(bus.req1_valid), 1);
            check("t5_grant", int'(grant_id), 0);
            tick();
        end
        wait_idle();
        stall_at0 = -1;
        check_rx("t5_rsp0", 0, 8, 1, 1);
        check_rx("t5_rsp1", 1, 8, 51, 1);
        check("t5_grants", grants.size(), 2);
        if (grants.size() == 2) check("t5_order", grants[1], 1);
        check("t5_eng_words", eng_words, 80);
        check("t5_err_grant", err_grant, 1);

        // reset while draining req1's job
        clear_logs();
        push_job(1, 1'b0, 0, 61, 1);
        for (int i = 0; i < 500 && rx1.size() < 3; i++) tick();
        check("t6_reached_drain", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_grant", int'(grant_id), 0);
        check("t6_err", int'(err_stale_w), 0);
        check("t6_outs", int'({bus.rsp0_valid, bus.rsp1_valid, bus.eng_output_ready,
                               bus.eng_input_valid, bus.req0_ready, bus.req1_ready, bus.eng_new_matrix}), 0);

        // after reset W is unowned: req0 x-only must flag stale W
        clear_logs();
        push_job(0, 1'b0, 0, 71, 1);
        wait_idle();
        check_rx("t6_rsp0", 0, 8, 71, 1);
        check("t6_err_cnt", err_cnt, 1);
        check("t6_err_grant", err_grant, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
